// File: rtl/membrane_integrator.sv
`default_nettype none
// ============================================================================
// Module      : membrane_integrator
// Description : Leaky integrate-and-fire membrane accumulator with a
//               refractory period. It integrates input current into the
//               membrane potential u, subtracting a shift-based leak and
//               saturating at the top of the range. On a spike reported by
//               the downstream threshold stage it either clears u or
//               subtracts theta, pulses spike_out for one cycle, and
//               optionally holds off for refrac_len cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   en          : global enable, low freezes all state
//   in_valid    : current sample present
//   in_ready    : sample accepted this cycle (en and INTEGRATE)
//   current     : unsigned input current, W bits
//   leak_shift  : leak = u >> leak_shift, 0 disables leak
//   theta       : threshold subtracted in subtract-reset mode
//   reset_mode  : 0 = clear u on spike, 1 = subtract theta on spike
//   refrac_len  : refractory cycles following a spike
//   is_spike    : threshold-compare result from the spike stage
//   u           : registered membrane potential
//   spike_out   : registered one-cycle spike pulse
// ============================================================================
module membrane_integrator #(
    parameter int N_STAGE  = 2,
    parameter int REFRAC_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_STAGE+1:0]    current,
    input  logic [2:0]            leak_shift,
    input  logic [N_STAGE+1:0]    theta,
    input  logic                  reset_mode,
    input  logic [REFRAC_W-1:0]   refrac_len,
    input  logic                  is_spike,
    output logic [N_STAGE+1:0]    u,
    output logic                  spike_out
);

    localparam int W = N_STAGE + 2;

    typedef enum logic [0:0] {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [W-1:0]        u_next;
    logic [REFRAC_W-1:0] cnt, cnt_next;
    logic                spike_next;

    logic [W-1:0]        leak;
    logic [W-1:0]        leaked;
    logic [W-1:0]        add_term;
    logic [W:0]          sum;
    logic [W-1:0]        u_sat;
    logic [W-1:0]        u_after_spike;

    assign in_ready = en && (state == ST_INTEGRATE);

    // Leak never exceeds u, so the subtraction cannot underflow; the add
    // is carried out one bit wider so overflow can be clamped.
    always_comb begin
        leak          = (leak_shift == 3'd0) ? '0 : (u >> leak_shift);
        leaked        = u - leak;
        add_term      = in_valid ? current : '0;
        sum           = {1'b0, leaked} + {1'b0, add_term};
        u_sat         = sum[W] ? {W{1'b1}} : sum[W-1:0];
        u_after_spike = '0;
        if (reset_mode && (u >= theta)) begin
            u_after_spike = u - theta;
        end
    end

    always_comb begin
        state_next = state;
        u_next     = u;
        cnt_next   = cnt;
        spike_next = 1'b0;
        if (en) begin
            case (state)
                ST_INTEGRATE: begin
                    if (is_spike) begin
                        // Spike wins; any presented sample is consumed and dropped.
                        spike_next = 1'b1;
                        u_next     = u_after_spike;
                        if (refrac_len != '0) begin
                            state_next = ST_REFRACTORY;
                            cnt_next   = refrac_len;
                        end
                    end else begin
                        u_next = u_sat;
                    end
                end
                ST_REFRACTORY: begin
                    // Counter was loaded with a nonzero length; <=1 also
                    // guards against ever sticking in this state.
                    if (cnt <= {{(REFRAC_W-1){1'b0}}, 1'b1}) begin
                        state_next = ST_INTEGRATE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                default: begin
                    state_next = ST_INTEGRATE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INTEGRATE;
            u         <= '0;
            cnt       <= '0;
            spike_out <= 1'b0;
        end else begin
            state     <= state_next;
            u         <= u_next;
            cnt       <= cnt_next;
            spike_out <= spike_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_membrane_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_membrane_integrator
// Description : Directed self-checking bench for membrane_integrator (W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membrane_integrator;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] current;
    logic [2:0] leak_shift;
    logic [3:0] theta;
    logic       reset_mode;
    logic [2:0] refrac_len;
    logic       is_spike;
    logic [3:0] u;
    logic       spike_out;

    logic       tie_spike;
    logic       spike_force;

    int tests;
    int fails;

    // Either a threshold comparator on u (>=10) or a directly forced value.
    assign is_spike = tie_spike ? (u >= 4'd10) : spike_force;

    membrane_integrator #(.N_STAGE(2), .REFRAC_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .current    (current),
        .leak_shift (leak_shift),
        .theta      (theta),
        .reset_mode (reset_mode),
        .refrac_len (refrac_len),
        .is_spike   (is_spike),
        .u          (u),
        .spike_out  (spike_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and return all inputs to idle defaults.
    task automatic do_reset();
        rst_n       = 1'b0;
        en          = 1'b1;
        in_valid    = 1'b0;
        current     = 4'd0;
        leak_shift  = 3'd0;
        theta       = 4'd0;
        reset_mode  = 1'b0;
        refrac_len  = 3'd0;
        tie_spike   = 1'b0;
        spike_force = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Load u with a value from zero using one accepted sample.
    task automatic load_u(input logic [3:0] v);
        do_reset();
        in_valid = 1'b1;
        current  = v;
        step();
        in_valid = 1'b0;
        current  = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (u !== 4'd0) begin
            fails++;
            $display("FAIL reset_u: got %0d expected 0", u);
        end
        tests++;
        if (spike_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_spike: got %b expected 0", spike_out);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_integrate();
        logic [3:0] exp_u [5];
        logic       exp_s [5];
        exp_u = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd0};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        tie_spike = 1'b1;
        in_valid  = 1'b1;
        current   = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (u !== exp_u[i] || spike_out !== exp_s[i]) begin
                fails++;
                $display("FAIL integrate[%0d]: got u=%0d spike=%b expected u=%0d spike=%b",
                         i, u, spike_out, exp_u[i], exp_s[i]);
            end
        end
        step();
        tests++;
        if (u !== 4'd3 || spike_out !== 1'b0) begin
            fails++;
            $display("FAIL integrate_after_spike: got u=%0d spike=%b expected u=3 spike=0",
                     u, spike_out);
        end
    endtask

    task automatic test_saturation();
        load_u(4'd15);
        in_valid = 1'b1;
        current  = 4'd5;
        step();
        tests++;
        if (u !== 4'd15) begin
            fails++;
            $display("FAIL saturation: got %0d expected 15", u);
        end
    endtask

    task automatic test_leak();
        logic [3:0] exp_u [4];
        exp_u = '{4'd4, 4'd2, 4'd1, 4'd1};
        load_u(4'd8);
        leak_shift = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (u !== exp_u[i]) begin
                fails++;
                $display("FAIL leak[%0d]: got %0d expected %0d", i, u, exp_u[i]);
            end
        end
    endtask

    task automatic test_subtract_reset();
        load_u(4'd13);
        reset_mode  = 1'b1;
        theta       = 4'd10;
        spike_force = 1'b1;
        in_valid    = 1'b1;
        current     = 4'd5;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL subtract_ready: got %b expected 1", in_ready);
        end
        step();
        tests++;
        if (u !== 4'd3 || spike_out !== 1'b1) begin
            fails++;
            $display("FAIL subtract_spike: got u=%0d spike=%b expected u=3 spike=1", u, spike_out);
        end
        spike_force = 1'b0;
        in_valid    = 1'b0;
        step();
        tests++;
        if (u !== 4'd3 || spike_out !== 1'b0) begin
            fails++;
            $display("FAIL subtract_pulse: got u=%0d spike=%b expected u=3 spike=0", u, spike_out);
        end
    endtask

    task automatic test_enable_freeze();
        load_u(4'd5);
        en          = 1'b0;
        in_valid    = 1'b1;
        current     = 4'd3;
        spike_force = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL freeze_ready: got %b expected 0", in_ready);
        end
        step();
        tests++;
        if (u !== 4'd5 || spike_out !== 1'b0) begin
            fails++;
            $display("FAIL freeze_hold: got u=%0d spike=%b expected u=5 spike=0", u, spike_out);
        end
        en          = 1'b1;
        spike_force = 1'b0;
        step();
        tests++;
        if (u !== 4'd8) begin
            fails++;
            $display("FAIL freeze_resume: got %0d expected 8", u);
        end
    endtask

    task automatic test_refractory();
        // en per cycle after the spike edge, expected in_ready before each edge
        logic en_seq  [5];
        logic rdy_exp [6];
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rdy_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        load_u(4'd12);
        reset_mode  = 1'b1;
        theta       = 4'd10;
        refrac_len  = 3'd3;
        spike_force = 1'b1;
        step();
        tests++;
        if (u !== 4'd2 || spike_out !== 1'b1) begin
            fails++;
            $display("FAIL refrac_spike: got u=%0d spike=%b expected u=2 spike=1", u, spike_out);
        end
        in_valid   = 1'b1;
        current    = 4'd5;
        refrac_len = 3'd7;
        for (int i = 0; i < 5; i++) begin
            en = en_seq[i];
            #1;
            tests++;
            if (in_ready !== rdy_exp[i]) begin
                fails++;
                $display("FAIL refrac_ready[%0d]: got %b expected %b", i, in_ready, rdy_exp[i]);
            end
            step();
            tests++;
            if (u !== 4'd2 || spike_out !== 1'b0) begin
                fails++;
                $display("FAIL refrac_hold[%0d]: got u=%0d spike=%b expected u=2 spike=0",
                         i, u, spike_out);
            end
        end
        spike_force = 1'b0;
        tests++;
        if (in_ready !== rdy_exp[5]) begin
            fails++;
            $display("FAIL refrac_exit: got %b expected %b", in_ready, rdy_exp[5]);
        end
        step();
        tests++;
        if (u !== 4'd7) begin
            fails++;
            $display("FAIL refrac_integrate: got %0d expected 7", u);
        end
    endtask

    task automatic test_async_reset();
        load_u(4'd12);
        refrac_len  = 3'd5;
        spike_force = 1'b1;
        step();
        tests++;
        if (spike_out !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL areset_pre: got spike=%b ready=%b expected spike=1 ready=0",
                     spike_out, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (u !== 4'd0 || spike_out !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got u=%0d spike=%b expected u=0 spike=0",
                     u, spike_out);
        end
        rst_n       = 1'b1;
        spike_force = 1'b0;
        in_valid    = 1'b1;
        current     = 4'd4;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL areset_ready: got %b expected 1", in_ready);
        end
        step();
        tests++;
        if (u !== 4'd4 || spike_out !== 1'b0) begin
            fails++;
            $display("FAIL areset_integrate: got u=%0d spike=%b expected u=4 spike=0",
                     u, spike_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_u [3];
        exp_u = '{4'd6, 4'd3, 4'd0};
        load_u(4'd9);
        reset_mode  = 1'b1;
        theta       = 4'd3;
        refrac_len  = 3'd0;
        spike_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (u !== exp_u[i] || spike_out !== 1'b1 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d]: got u=%0d spike=%b ready=%b expected u=%0d spike=1 ready=1",
                         i, u, spike_out, in_ready, exp_u[i]);
            end
        end
        spike_force = 1'b0;
        step();
        tests++;
        if (spike_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got %b expected 0", spike_out);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        en          = 1'b1;
        in_valid    = 1'b0;
        current     = 4'd0;
        leak_shift  = 3'd0;
        theta       = 4'd0;
        reset_mode  = 1'b0;
        refrac_len  = 3'd0;
        tie_spike   = 1'b0;
        spike_force = 1'b0;
        #2;
        test_reset();
        test_integrate();
        test_saturation();
        test_leak();
        test_subtract_reset();
        test_enable_freeze();
        test_refractory();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/membrane_integrator.md
MEMBRANE_INTEGRATOR -- requirements
Module: membrane_integrator

Interface
REQ-001 Parameter N_STAGE, default 2, width selector; membrane width W = N_STAGE+2, matching the spike stage's u/minus_teta width.
REQ-002 Parameter REFRAC_W, default 3, width of refractory length field.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global enable; low = freeze all state.
REQ-006 in_valid  input  1  input current sample present this cycle.
REQ-007 in_ready  output  1  block accepts current this cycle (combinational: en and state INTEGRATE).
REQ-008 current  input  W  unsigned input current sample.
REQ-009 leak_shift  input  3  leak = u >> leak_shift; 0 disables leak.
REQ-010 theta  input  W  unsigned threshold, used in subtract-reset mode.
REQ-011 reset_mode  input  1  0 = reset u to zero on spike, 1 = subtract theta on spike.
REQ-012 refrac_len  input  REFRAC_W  refractory cycles after a spike.
REQ-013 is_spike  input  1  threshold-compare result from the downstream spike stage, computed combinationally from u; high = u at/above threshold.
REQ-014 u  output  W  registered membrane potential, drives the spike stage.
REQ-015 spike_out  output  1  registered one-cycle spike pulse.

Function
REQ-016 States: INTEGRATE, REFRACTORY; reset state INTEGRATE.
REQ-017 en=0: u, state, counter held; spike_out driven 0 next edge; in_ready 0.
REQ-018 INTEGRATE, en=1, is_spike=0: u <= sat(u - leak + (in_valid ? current : 0)); leak = (leak_shift==0) ? 0 : u >> leak_shift; sum computed at W+1 bits, saturate to 2^W-1.
REQ-019 INTEGRATE, en=1, is_spike=1: spike has priority; current discarded (in_ready still 1, sample consumed and dropped); spike_out <= 1.
REQ-020 On spike, reset_mode=0: u <= 0; reset_mode=1: u <= (u >= theta) ? u - theta : 0.
REQ-021 On spike, refrac_len=0: remain INTEGRATE; else state <= REFRACTORY, counter <= refrac_len.
REQ-022 REFRACTORY, en=1: u held, is_spike ignored, in_valid ignored (in_ready 0), spike_out <= 0, counter decrements; counter==1 -> state <= INTEGRATE, counter <= 0.
REQ-023 Refractory duration exactly refrac_len cycles with en=1; en=0 cycles not counted.
REQ-024 spike_out high for exactly one cycle per accepted spike; back-to-back spikes possible only when refrac_len=0.
REQ-025 Latency: current sampled at edge k appears in u after edge k; spike_out asserts the edge after is_spike is seen.
REQ-026 refrac_len, reset_mode, theta, leak_shift sampled only at the edge where used; changes mid-refractory do not alter the running counter.

Reset
REQ-027 rst_n low: immediately u=0, spike_out=0, state=INTEGRATE, counter=0, regardless of clk.
REQ-028 Reset asserted mid-refractory aborts refractory; first edge after release behaves as INTEGRATE.
REQ-029 No output X after reset; in_ready = en after reset.

Verification (W=4)
REQ-030 Reset, leak_shift=0, in_valid=1, current=3 each cycle, is_spike tied to (u>=10) -> u: 3,6,9,12, then spike_out pulse, u=0 (reset_mode=0).
REQ-031 u=15, current=5, no spike (is_spike forced 0) -> u stays 15 (saturation).
REQ-032 u=8, leak_shift=1, in_valid=0 -> u: 4,2,1,1 (1>>1=0 leak).
REQ-033 reset_mode=1, theta=10, u=13, is_spike=1 -> u=3, spike_out=1 one cycle.
REQ-034 refrac_len=3 after spike -> in_ready 0 for 3 cycles, current ignored, is_spike=1 ignored; en=0 for 2 cycles mid-refractory extends window to 5 cycles.
REQ-035 rst_n pulsed low between edges during REFRACTORY -> u=0, spike_out=0 immediately, in_ready=1 after release.
